// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DEF_AW           = 8;
    localparam int DEF_DW           = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    // IDLE: core owns the port, GNT: host owns the port, ACK: core owns, host acked
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating conflict counter: counts cycles the host lost to the core and
// flags when the host must be allowed to win.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int             CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIM_C = CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    assign at_limit_o = (cnt_q == LIM_C);

    // Clear has priority over increment; increment stops at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path (fixed priority)
// and a host debug/loader port (req/ack, registered read data).
// Optional feature macro: DMEM_ARBITER_HOST_LOCK_EN adds a host_lock input that
// hands the port to the host permanently while asserted.
//
// Host handshake: host_req is raised with host_wen/host_addr/host_wdat and all
// of them are held stable until the single-cycle host_ack pulse; host_rdat is
// valid with that pulse and stays until the next ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          core_req,
    input  logic          core_wen,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic [DW-1:0] core_rdat,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_wen,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
`ifdef DMEM_ARBITER_HOST_LOCK_EN
    input  logic          host_lock,
`endif
    output logic          host_ack,
    output logic [DW-1:0] host_rdat,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    output arb_state_e    dbg_state_o
);

    arb_state_e    state_q, state_d;
    logic [DW-1:0] host_rdat_q;
    logic          lock;
    logic          at_limit;
    logic          host_owns;
    logic          enter_gnt;
    logic          cnt_inc;
    logic          cnt_clr;

`ifdef DMEM_ARBITER_HOST_LOCK_EN
    assign lock = host_lock;
`else
    assign lock = 1'b0;
`endif

    assign host_owns = (state_q == ST_GNT);

    // Next-state: core wins in IDLE unless idle itself, starved out, or locked out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (host_req && (!core_req || at_limit || lock)) state_d = ST_GNT;
            ST_GNT:  state_d = ST_ACK;
            ST_ACK:  state_d = (lock && host_req) ? ST_GNT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_gnt = (state_d == ST_GNT) && !host_owns;
    assign cnt_inc   = (state_q == ST_IDLE) && host_req && core_req && !enter_gnt;
    assign cnt_clr   = enter_gnt || ((state_q == ST_IDLE) && !host_req) || lock;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .inc_i      (cnt_inc),
        .clr_i      (cnt_clr),
        .at_limit_o (at_limit)
    );

    // FSM state and the host read-data capture taken at the GNT edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            host_rdat_q <= '0;
        end else begin
            state_q <= state_d;
            if (host_owns) begin
                host_rdat_q <= mem_rdat;
            end
        end
    end

    // Port mux: host drives memory only during GNT; a stalled core write is
    // re-presented by the core afterwards, so it lands after the host's.
    always_comb begin
        mem_addr = host_owns ? host_addr : core_addr;
        mem_wdat = host_owns ? host_wdat : core_wdat;
        mem_wen  = host_owns ? host_wen  : (core_req && core_wen && !lock);
    end

    assign core_stall  = core_req && (host_owns || lock);
    assign core_rdat   = mem_rdat;
    assign host_ack    = (state_q == ST_ACK);
    assign host_rdat   = host_rdat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven vectors, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIMIT = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       core_req = 1'b0, core_wen = 1'b0;
    logic [7:0] core_addr = '0, core_wdat = '0;
    logic [7:0] core_rdat;
    logic       core_stall;
    logic       host_req = 1'b0, host_wen = 1'b0;
    logic [7:0] host_addr = '0, host_wdat = '0;
    logic       host_lock = 1'b0;
    logic       host_ack;
    logic [7:0] host_rdat;
    logic       mem_wen;
    logic [7:0] mem_addr, mem_wdat, mem_rdat;
    arb_state_e dbg_state;

    logic [7:0] dmem [256] = '{default: 8'h00};

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(LIMIT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .core_req    (core_req),
        .core_wen    (core_wen),
        .core_addr   (core_addr),
        .core_wdat   (core_wdat),
        .core_rdat   (core_rdat),
        .core_stall  (core_stall),
        .host_req    (host_req),
        .host_wen    (host_wen),
        .host_addr   (host_addr),
        .host_wdat   (host_wdat),
`ifdef DMEM_ARBITER_HOST_LOCK_EN
        .host_lock   (host_lock),
`endif
        .host_ack    (host_ack),
        .host_rdat   (host_rdat),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdat    (mem_wdat),
        .mem_rdat    (mem_rdat),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / memory model / protocol monitor ----------------
    always #5 Clk = ~Clk;

    assign mem_rdat = dmem[mem_addr];
    always @(posedge Clk) if (mem_wen) dmem[mem_addr] <= mem_wdat;

    logic prev_pending;
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) prev_pending <= 1'b0;
        else begin
            if (prev_pending && !host_req) $error("host_req dropped before ack");
            prev_pending <= host_req && !host_ack;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_core(input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
        core_req = rq; core_wen = we; core_addr = a; core_wdat = d;
    endtask

    task automatic set_host(input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
        host_req = rq; host_wen = we; host_addr = a; host_wdat = d;
    endtask

    task automatic reset_dut();
        Reset = 1'b0;
        set_core(0, 0, 8'h00, 8'h00);
        set_host(0, 0, 8'h00, 8'h00);
        host_lock = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       creq, cwen;
        logic [7:0] caddr, cwdat;
        logic       hreq, hwen;
        logic [7:0] haddr, hwdat;
        logic       ewen;
        logic [7:0] eaddr, ewdat;
        logic       estall, eack;
        logic [7:0] erdat;
    } vec_t;

    function automatic vec_t mk(input logic cr, cw, input logic [7:0] ca, cd,
                                input logic hr, hw, input logic [7:0] ha, hd,
                                input logic ew, input logic [7:0] ea, ed,
                                input logic es, ek, input logic [7:0] er);
        vec_t v;
        v.creq = cr; v.cwen = cw; v.caddr = ca; v.cwdat = cd;
        v.hreq = hr; v.hwen = hw; v.haddr = ha; v.hwdat = hd;
        v.ewen = ew; v.eaddr = ea; v.ewdat = ed;
        v.estall = es; v.eack = ek; v.erdat = er;
        return v;
    endfunction

    vec_t vt [14];

    // ---------------- randomized run with reference model ----------------
    logic [7:0] model_mem [256];

    task automatic random_run(input int ncyc);
        int phase = 0;      // 0: host not granted, 1: grant cycle, 2: ack cycle
        int waited = 0;     // conflict cycles the pending request has lost
        bit h_active = 0;
        bit core_hold = 0;
        logic [7:0] m_rdat;
        logic       e_wen;
        logic [7:0] e_addr, e_wdat;
        for (int a = 0; a < 256; a++) model_mem[a] = dmem[a];
        m_rdat = host_rdat;  // host_rdat value left by the previous sequence is checked below
        chk("rnd_start_rdat", host_rdat, 8'hA5);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            if (!h_active) begin
                host_req = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    h_active = 1;
                    set_host(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                             8'($urandom_range(0, 255)));
                end
            end
            if (!core_hold)
                set_core(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            #1;
            if (phase == 1) begin
                e_addr = host_addr; e_wdat = host_wdat; e_wen = host_wen;
            end else begin
                e_addr = core_addr; e_wdat = core_wdat; e_wen = core_req && core_wen;
            end
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdat", mem_wdat, e_wdat);
            chk("rnd_mem_wen", mem_wen, e_wen);
            chk("rnd_stall", core_stall, (phase == 1) && core_req);
            chk("rnd_ack", host_ack, phase == 2);
            chk("rnd_rdat", host_rdat, m_rdat);
            @(posedge Clk);
            if (phase == 1) begin
                m_rdat = model_mem[host_addr];
                if (host_wen) model_mem[host_addr] = host_wdat;
                core_hold = core_req;
                phase = 2;
            end else begin
                core_hold = 0;
                if (core_req && core_wen) model_mem[core_addr] = core_wdat;
                if (phase == 2) begin
                    phase = 0;
                    h_active = 0;
                end else if (host_req) begin
                    if (!core_req || waited == LIMIT) begin
                        phase = 1;
                        waited = 0;
                    end else if (waited < LIMIT) begin
                        waited++;
                    end
                end else begin
                    waited = 0;
                end
            end
        end
        // let any open transaction complete with the core quiet
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            set_core(0, 0, 8'h00, 8'h00);
            if (!h_active) host_req = 1'b0;
            @(posedge Clk);
            if (phase == 1) begin
                if (host_wen) model_mem[host_addr] = host_wdat;
                phase = 2;
            end else if (phase == 2) begin
                phase = 0;
                h_active = 0;
            end else if (host_req) begin
                phase = 1;
            end
        end
        begin
            int bad = 0;
            for (int a = 0; a < 256; a++) if (dmem[a] !== model_mem[a]) bad++;
            chk("rnd_mem_final_mismatches", bad, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int gnt_idx, ack_idx;

        vt[0]  = mk(1,1,8'h05,8'h3C, 0,0,8'h00,8'h00, 1,8'h05,8'h3C,0,0,8'h00);
        vt[1]  = mk(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, 0,8'h05,8'h00,0,0,8'h00);
        vt[2]  = mk(0,1,8'h44,8'h99, 1,1,8'h10,8'hA5, 0,8'h44,8'h99,0,0,8'h00);
        vt[3]  = mk(0,1,8'h44,8'h99, 1,1,8'h10,8'hA5, 1,8'h10,8'hA5,0,0,8'h00);
        vt[4]  = mk(1,0,8'h05,8'h00, 1,1,8'h10,8'hA5, 0,8'h05,8'h00,0,1,8'h00);
        vt[5]  = mk(0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,8'h00,8'h00,0,0,8'h00);
        vt[6]  = mk(0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,8'h10,8'h00,0,0,8'h00);
        vt[7]  = mk(0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,8'h00,8'h00,0,1,8'hA5);
        vt[8]  = mk(1,1,8'h06,8'h77, 0,0,8'h00,8'h00, 1,8'h06,8'h77,0,0,8'hA5);
        vt[9]  = mk(1,0,8'h06,8'h00, 1,0,8'h05,8'h00, 0,8'h06,8'h00,0,0,8'hA5);
        vt[10] = mk(0,0,8'h06,8'h00, 1,0,8'h05,8'h00, 0,8'h06,8'h00,0,0,8'hA5);
        vt[11] = mk(1,1,8'h07,8'h55, 1,0,8'h05,8'h00, 0,8'h05,8'h00,1,0,8'hA5);
        vt[12] = mk(1,1,8'h07,8'h55, 1,0,8'h05,8'h00, 1,8'h07,8'h55,0,1,8'h3C);
        vt[13] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,8'h00,8'h00,0,0,8'h3C);

        // reset state
        Reset = 1'b0;
        #2;
        chk("reset_state", dbg_state, ST_IDLE);
        chk("reset_ack", host_ack, 0);
        chk("reset_rdat", host_rdat, 8'h00);
        chk("reset_stall", core_stall, 0);
        reset_dut();

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge Clk);
            set_core(vt[i].creq, vt[i].cwen, vt[i].caddr, vt[i].cwdat);
            set_host(vt[i].hreq, vt[i].hwen, vt[i].haddr, vt[i].hwdat);
            #1;
            chk($sformatf("vec%0d_mem_wen", i), mem_wen, vt[i].ewen);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].eaddr);
            chk($sformatf("vec%0d_mem_wdat", i), mem_wdat, vt[i].ewdat);
            chk($sformatf("vec%0d_stall", i), core_stall, vt[i].estall);
            chk($sformatf("vec%0d_ack", i), host_ack, vt[i].eack);
            chk($sformatf("vec%0d_rdat", i), host_rdat, vt[i].erdat);
        end
        chk("tbl_mem_10", dmem[8'h10], 8'hA5);
        chk("tbl_mem_07", dmem[8'h07], 8'h55);

        // reset mid-traffic, asserted during an ACK cycle
        @(negedge Clk); set_host(1, 0, 8'h10, 8'h00); set_core(0, 0, 8'h00, 8'h00);
        @(negedge Clk);
        @(negedge Clk); set_core(1, 0, 8'h05, 8'h00);
        #1;
        chk("rst_pre_ack", host_ack, 1);
        chk("rst_pre_rdat", host_rdat, 8'hA5);
        Reset = 1'b0;
        #1;
        chk("rst_mid_ack", host_ack, 0);
        chk("rst_mid_rdat", host_rdat, 8'h00);
        chk("rst_mid_stall", core_stall, 0);
        chk("rst_mid_state", dbg_state, ST_IDLE);
        set_host(0, 0, 8'h00, 8'h00);
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1; set_core(0, 0, 8'h00, 8'h00);

        // starvation: core requests every cycle, host read pending
        @(negedge Clk);
        set_core(1, 0, 8'h01, 8'h00);
        set_host(1, 0, 8'h10, 8'h00);
        gnt_idx = -1; ack_idx = -1;
        for (int idx = 0; idx < 20; idx++) begin
            if (idx != 0) @(negedge Clk);
            if (ack_idx >= 0) host_req = 1'b0;
            #1;
            if (dbg_state == ST_GNT && gnt_idx < 0) begin
                gnt_idx = idx;
                chk("starve_gnt_stall", core_stall, 1);
            end
            if (host_ack && ack_idx < 0) begin
                ack_idx = idx;
                chk("starve_rdat", host_rdat, 8'hA5);
            end
        end
        chk("starve_gnt_cycle", gnt_idx, LIMIT + 1);
        chk("starve_ack_cycle", ack_idx, LIMIT + 2);

        // same-address collision: host write then stalled core write
        @(negedge Clk); set_core(0, 0, 8'h00, 8'h00); set_host(1, 1, 8'h20, 8'h11);
        @(negedge Clk); set_core(1, 1, 8'h20, 8'h22);
        #1;
        chk("coll_state_gnt", dbg_state, ST_GNT);
        chk("coll_stall", core_stall, 1);
        chk("coll_host_wdat", mem_wdat, 8'h11);
        @(negedge Clk);
        #1;
        chk("coll_ack", host_ack, 1);
        chk("coll_core_wen", mem_wen, 1);
        chk("coll_core_wdat", mem_wdat, 8'h22);
        @(negedge Clk); set_core(0, 0, 8'h00, 8'h00); set_host(0, 0, 8'h00, 8'h00);
        #1;
        chk("coll_mem_20", dmem[8'h20], 8'h22);

        // reset during GNT of a host write
        @(negedge Clk); set_host(1, 1, 8'h30, 8'h7E);
        @(negedge Clk);
        #1;
        chk("rstg_state_gnt", dbg_state, ST_GNT);
        chk("rstg_wen_pre", mem_wen, 1);
        Reset = 1'b0;
        #1;
        chk("rstg_state_idle", dbg_state, ST_IDLE);
        chk("rstg_wen_post", mem_wen, 0);
        set_host(0, 0, 8'h00, 8'h00);
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        begin
            int acks = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge Clk); #1;
                if (host_ack) acks++;
            end
            chk("rstg_no_ack", acks, 0);
        end
        chk("rstg_mem_30", dmem[8'h30], 8'h00);

`ifdef DMEM_ARBITER_HOST_LOCK_EN
        // host lock: four back-to-back host writes, core locked out
        begin
            int nreq = 0;
            int ack_cnt = 0;
            int ack_at [4];
            @(negedge Clk);
            host_lock = 1'b1;
            set_host(1, 1, 8'h40, 8'hC0);
            for (int c = 0; c < 14; c++) begin
                if (c != 0) @(negedge Clk);
                if (host_ack && ack_cnt < 4) begin
                    ack_at[ack_cnt] = c;
                    ack_cnt++;
                    nreq++;
                    if (nreq < 4) set_host(1, 1, 8'(8'h40 + nreq), 8'(8'hC0 + nreq));
                    else host_req = 1'b0;
                end
                set_core(1'($urandom_range(0, 1)), 1, 8'(8'h80 + c), 8'h5A);
                #1;
                chk("lock_stall", core_stall, core_req);
                chk("lock_wen", mem_wen, dbg_state == ST_GNT);
            end
            chk("lock_ack_count", ack_cnt, 4);
            for (int k = 0; k < 4; k++) begin
                if (k < ack_cnt) chk($sformatf("lock_ack%0d_cycle", k), ack_at[k], 2 * (k + 1));
                chk($sformatf("lock_mem_%0d", k), dmem[8'h40 + k], 8'(8'hC0 + k));
            end
            begin
                int cw = 0;
                for (int a = 8'h80; a < 8'h8E; a++) if (dmem[a] != 8'h00) cw++;
                chk("lock_no_core_writes", cw, 0);
            end
            @(negedge Clk);
            host_lock = 1'b0;
            set_core(0, 0, 8'h00, 8'h00);
            set_host(0, 0, 8'h00, 8'h00);
            repeat (2) @(negedge Clk);
        end
`endif

        // randomized run against the reference model; first re-establish a
        // known host_rdat by reading 0x10
        @(negedge Clk); set_core(0, 0, 8'h00, 8'h00); set_host(1, 0, 8'h10, 8'h00);
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk); set_host(0, 0, 8'h00, 8'h00);
        random_run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the processor core's load/store path and a host debug/loader port. Sits between the core's load/store path and `DMem`, and drives the core stall that freezes the program counter and register write-back. The core has fixed priority, and a starvation counter bounds host wait time. Host accesses use a req/ack handshake with a registered read-data return.

## Interface
- `AW`, 8, memory address width
- `DW`, 8, memory data width
- `STARVE_LIMIT`, 4, conflict cycles tolerated before host forcibly wins (≥1)

- `Clk`  input  1  clock
- `Reset`  input  1  asynchronous, active-low reset
- `core_req`  input  1  core memory access this cycle
- `core_wen`  input  1  core access is a write
- `core_addr`  input  AW  core address
- `core_wdat`  input  DW  core write data
- `core_rdat`  output  DW  read data to core (= `mem_rdat`)
- `core_stall`  output  1  core must hold PC, suppress write-back, re-present access
- `host_req`  input  1  host request; held stable with addr/wen/wdat until ack
- `host_wen`  input  1  host access is a write
- `host_addr`  input  AW  host address
- `host_wdat`  input  DW  host write data
- `host_ack`  output  1  one-cycle completion pulse
- `host_rdat`  output  DW  registered read data, valid with `host_ack`, held until next ack
- `mem_wen`  output  1  DMem write enable
- `mem_addr`  output  AW  DMem address
- `mem_wdat`  output  DW  DMem write data
- `mem_rdat`  input  DW  DMem combinational read data

## Operation
- States:
  - IDLE: core owns port.
  - GNT: host owns port for one cycle.
  - ACK: core owns port, `host_ack`=1.
- Port mux in IDLE/ACK: `mem_addr`=`core_addr`, `mem_wdat`=`core_wdat`, `mem_wen`=`core_req`&`core_wen`.
- Port mux in GNT: `mem_addr`=`host_addr`, `mem_wdat`=`host_wdat`, `mem_wen`=`host_wen`.
- `core_stall` = (state==GNT) & `core_req`; core access is retried the next cycle.
- IDLE→GNT when `host_req` & (!`core_req` | `starve_cnt`==`STARVE_LIMIT`); otherwise stay in IDLE.
- GNT→ACK unconditionally. `host_rdat`<=`mem_rdat` at the GNT clock edge; a host write commits at the same edge.
- ACK→IDLE unconditionally. `host_req` is ignored in ACK; a held request is re-evaluated in IDLE.
- `starve_cnt`, width $clog2(`STARVE_LIMIT`+1):
  - increments, saturating at `STARVE_LIMIT`, in IDLE when `host_req`&`core_req` and no grant is issued;
  - clears on entry to GNT;
  - clears in IDLE when `host_req`=0.
- Same-address conflict: a core write stalled by a GNT lands one cycle after the host's write, so the final value is the core's.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, `host_ack` 0, `host_rdat` 0, `core_stall` 0. Mux outputs follow the core inputs.
- Host latency with core idle: request sampled in IDLE (cycle 0), GNT in cycle 1, ack in cycle 2. Peak throughput is one access per 3 cycles.
- Worst-case host wait under continuous core traffic: `STARVE_LIMIT`+1 IDLE cycles, then GNT.
- Each forced host win costs the core exactly one stall cycle.
- Reset mid-operation: the state clears asynchronously. A GNT in progress produces no write (the mux reverts immediately) and no ack, so the host must reissue.
- `host_req` dropped before ack is a protocol violation. Behaviour is undefined, and the bench asserts against it.

## Configuration
- `DMEM_ARBITER_HOST_LOCK_EN` defined:
  - adds input `host_lock` (1 bit);
  - while `host_lock`=1, core never owns the port: core-side `mem_wen` is gated to 0, `core_stall`=`core_req`;
  - IDLE or ACK go to GNT whenever `host_req`=1, giving one host access per 2 cycles;
  - `starve_cnt` is held at 0.
- Not defined: no `host_lock` port; behaviour exactly as above.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, GNT, ACK) and default `AW`/`DW`/`STARVE_LIMIT` constants.
- Sub-module `arb_starve_ctr`: saturating counter with inc/clr inputs and an at-limit output.
- The FSM, port mux and `host_rdat` register live in `dmem_arbiter`.

## Test plan
- Reset: drive `Reset`=0 mid-traffic -> `host_ack`=0, `host_rdat`=0x00, `core_stall`=0, state IDLE.
- Host write then read, core idle: write 0xA5 to 0x10 -> `mem_wen`=1 at addr 0x10 in cycle 1, ack in cycle 2. A following read of 0x10 -> `host_rdat`=0xA5 with ack.
- Starvation, `STARVE_LIMIT`=4, `core_req`=1 every cycle, host read pending -> cycles 1–4 counted, decision in cycle 5, GNT in cycle 6 with `core_stall`=1, ack in cycle 7.
- Collision: host write 0x11 and core write 0x22, both to addr 0x20, core stalled in GNT -> next cycle core write lands, mem[0x20]=0x22.
- Reset during GNT with host write 0x7E to 0x30 -> mem[0x30] unchanged, no `host_ack`, state IDLE.
- `DMEM_ARBITER_HOST_LOCK_EN`, `host_lock`=1, 4 back-to-back host writes -> acks every 2nd cycle, `core_stall`=`core_req` throughout, no core write reaches memory.
